// File: rtl/switch_input_unit.sv
// switch_input_unit: per-input-port front end of the switch.
// NUM_VCS virtual-channel FIFOs, round-robin VC selection with wormhole lock
// until the tail flit, diversion of switch-config packets addressed to NODE
// onto the cfg port, and one registered credit per popped flit.
// Optional build macro: SWITCH_IU_PERF_EN adds perf_flits / perf_stall counters.

// One virtual-channel FIFO; write to a full FIFO succeeds only when it pops in the same cycle.
module siu_vc_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         rd,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_wr, do_rd;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_rd   = rd && !empty;
  assign do_wr   = wr && (!full || do_rd);
  assign rd_data = mem[rptr];

  // storage array, not reset (pointers define validity)
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end
endmodule

module switch_input_unit #(
  parameter int          FLIT_W         = 32,
  parameter int          NUM_VCS        = 2,
  parameter int          DEPTH          = 8,
  parameter logic [4:0]  NODE           = 5'd3,
  parameter logic [3:0]  FMT_SWITCH_CFG = 4'hF,
  localparam int         VC_W           = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic [VC_W-1:0]   in_vc,
  input  logic              in_last,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  output logic [VC_W-1:0]   out_vc,
  output logic              out_head,
  output logic              out_last,
  input  logic              out_ready,
  output logic              cfg_valid,
  output logic [FLIT_W-1:0] cfg_flit,
  output logic              cfg_last,
  output logic              credit_valid,
  output logic [VC_W-1:0]   credit_vc,
  output logic              err_overflow
`ifdef SWITCH_IU_PERF_EN
  ,
  output logic [31:0]       perf_flits,
  output logic [31:0]       perf_stall
`endif
);
  typedef struct packed {
    logic              last;
    logic [FLIT_W-1:0] flit;
  } ent_t;

  typedef enum logic [1:0] {IDLE, FWD, CLAIM} state_t;

  state_t                   state, state_nxt;
  ent_t [NUM_VCS-1:0]       head_data;
  logic [NUM_VCS-1:0]       empty, full, wr_en, rd_en, head_flag;
  logic [VC_W-1:0]          wr_vc, lock_vc, rr_ptr, arb_vc;
  logic                     arb_found, cfg_hit, pop, drop, vc_ok;
  ent_t                     lock_ent, arb_ent;

  // single-VC builds ignore the VC field entirely
  assign wr_vc    = (NUM_VCS == 1) ? '0 : in_vc;
  assign vc_ok    = (int'(wr_vc) < NUM_VCS);
  assign lock_ent = head_data[lock_vc];
  assign arb_ent  = head_data[arb_vc];
  assign cfg_hit  = (arb_ent.flit[31:28] == FMT_SWITCH_CFG) && (arb_ent.flit[27:23] == NODE);
  assign drop     = in_valid && vc_ok && full[wr_vc] && !rd_en[wr_vc];

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign wr_en[v] = in_valid && (wr_vc == VC_W'(v));
    assign rd_en[v] = pop && (lock_vc == VC_W'(v));
    siu_vc_fifo #(.W($bits(ent_t)), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .wr      (wr_en[v]),
      .wr_data ({in_last, in_flit}),
      .rd      (rd_en[v]),
      .rd_data (head_data[v]),
      .empty   (empty[v]),
      .full    (full[v])
    );
  end

  // round-robin pick: first non-empty VC after rr_ptr
  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_vc    = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_VCS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_VCS;
      if (!arb_found && !empty[idx]) begin
        arb_found = 1'b1;
        arb_vc    = VC_W'(idx);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: lock on arbitration, release after the tail pops
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_found) state_nxt = cfg_hit ? CLAIM : FWD;
      FWD,
      CLAIM:   if (pop && lock_ent.last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: present head of the locked VC; idle outputs are zero
  always_comb begin
    out_valid = 1'b0;
    cfg_valid = 1'b0;
    case (state)
      FWD:     out_valid = !empty[lock_vc];
      CLAIM:   cfg_valid = !empty[lock_vc];
      default: ;
    endcase
    pop      = (out_valid && out_ready) || cfg_valid;
    out_flit = out_valid ? lock_ent.flit : '0;
    out_vc   = out_valid ? lock_vc : '0;
    out_head = out_valid && head_flag[lock_vc];
    out_last = out_valid && lock_ent.last;
    cfg_flit = cfg_valid ? lock_ent.flit : '0;
    cfg_last = cfg_valid && lock_ent.last;
  end

  // lock, rr pointer, head flags, credits and sticky overflow
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      lock_vc      <= '0;
      rr_ptr       <= '0;
      head_flag    <= '1;
      credit_valid <= 1'b0;
      credit_vc    <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (state == IDLE && arb_found) lock_vc <= arb_vc;
      if (state == FWD && pop && lock_ent.last) rr_ptr <= lock_vc;
      if (pop) head_flag[lock_vc] <= lock_ent.last;
      credit_valid <= pop;
      credit_vc    <= pop ? lock_vc : '0;
      if (drop) err_overflow <= 1'b1;
    end
  end

`ifdef SWITCH_IU_PERF_EN
  // saturating forward-pop and stall counters
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      perf_flits <= '0;
      perf_stall <= '0;
    end else begin
      if (out_valid && out_ready && perf_flits != 32'hFFFF_FFFF) perf_flits <= perf_flits + 32'd1;
      if (out_valid && !out_ready && perf_stall != 32'hFFFF_FFFF) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_switch_input_unit.sv
// Bench for switch_input_unit: directed scenarios then random traffic, all
// checked every cycle against a queue-based reference model.
module tb_switch_input_unit;
  localparam int         FW  = 32;
  localparam int         NV  = 2;
  localparam int         DP  = 4;
  localparam logic [4:0] NID = 5'd9;
  localparam logic [3:0] FMT = 4'hF;

  logic          clk = 1'b0;
  logic          n_rst, in_valid, in_last, out_ready;
  logic [FW-1:0] in_flit;
  logic          in_vc;
  logic          out_valid, out_head, out_last, cfg_valid, cfg_last;
  logic [FW-1:0] out_flit, cfg_flit;
  logic          out_vc, credit_valid, credit_vc, err_overflow;

  always #5 clk = ~clk;

  switch_input_unit #(.FLIT_W(FW), .NUM_VCS(NV), .DEPTH(DP), .NODE(NID), .FMT_SWITCH_CFG(FMT)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_flit(in_flit), .in_vc(in_vc),
    .in_last(in_last), .out_valid(out_valid), .out_flit(out_flit), .out_vc(out_vc),
    .out_head(out_head), .out_last(out_last), .out_ready(out_ready), .cfg_valid(cfg_valid),
    .cfg_flit(cfg_flit), .cfg_last(cfg_last), .credit_valid(credit_valid),
    .credit_vc(credit_vc), .err_overflow(err_overflow)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // reference model: one queue of {last,flit} per VC plus packet-level lock
  logic [32:0] q[NV][$];
  bit          mhead[NV];
  int          mode;      // 0 none locked, 1 forwarding, 2 claimed by cfg
  int          lock, rr;
  bit          mcv, merr, chk_en = 1'b0;
  int          mcvc;

  function automatic logic [31:0] cfg_word(input logic [22:0] low);
    return {FMT, NID, low};
  endfunction

  task automatic step(input bit rst_n, input bit v, input logic [31:0] f, input int vc,
                      input bit l, input bit rdy);
    bit ov, cv, pop, found;
    logic [32:0] front;
    int plock, w;
    @(negedge clk);
    n_rst = rst_n; in_valid = v; in_flit = f; in_vc = vc[0]; in_last = l; out_ready = rdy;
    #1;
    ov    = (mode == 1) && (q[lock].size() > 0);
    cv    = (mode == 2) && (q[lock].size() > 0);
    front = (ov || cv) ? q[lock][0] : '0;
    if (chk_en) begin
      chk("out_valid", out_valid, ov);
      chk("out_flit",  out_flit,  ov ? front[31:0] : 32'd0);
      chk("out_vc",    out_vc,    ov ? lock : 0);
      chk("out_head",  out_head,  ov && mhead[lock]);
      chk("out_last",  out_last,  ov && front[32]);
      chk("cfg_valid", cfg_valid, cv);
      chk("cfg_flit",  cfg_flit,  cv ? front[31:0] : 32'd0);
      chk("cfg_last",  cfg_last,  cv && front[32]);
      chk("credit_valid", credit_valid, mcv);
      chk("credit_vc", credit_vc, mcvc);
      chk("err_overflow", err_overflow, merr);
    end
    if (!rst_n) begin
      for (int i = 0; i < NV; i++) begin q[i].delete(); mhead[i] = 1'b1; end
      mode = 0; lock = 0; rr = 0; mcv = 0; mcvc = 0; merr = 0; chk_en = 1'b1;
      return;
    end
    pop   = (ov && rdy) || cv;
    plock = lock;
    if (pop) begin
      void'(q[plock].pop_front());
      mhead[plock] = front[32];
    end
    if (mode == 0) begin
      found = 1'b0;
      for (int i = 1; i <= NV; i++) begin
        w = (rr + i) % NV;
        if (!found && q[w].size() > 0) begin
          found = 1'b1;
          lock  = w;
          mode  = (q[w][0][31:28] == FMT && q[w][0][27:23] == NID) ? 2 : 1;
        end
      end
    end else if (pop && front[32]) begin
      if (mode == 1) rr = plock;
      mode = 0;
    end
    if (v) begin
      if (q[vc].size() < DP) q[vc].push_back({l, f});
      else merr = 1'b1;
    end
    mcv  = pop;
    mcvc = pop ? plock : 0;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1, 0, 32'd0, 0, 0, rdy);
  endtask

  initial begin
    n_rst = 0; in_valid = 0; in_flit = '0; in_vc = 0; in_last = 0; out_ready = 0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(2, 1);
    // single 3-flit packet on VC0
    step(1, 1, 32'h1111_0001, 0, 0, 1);
    step(1, 1, 32'h1111_0002, 0, 0, 1);
    step(1, 1, 32'h1111_0003, 0, 1, 1);
    idle(6, 1);
    // interleaved writes to VC0 and VC1
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 32'h2000_0000 + i, 0, i == 2, 1);
      step(1, 1, 32'h3000_0000 + i, 1, i == 2, 1);
    end
    idle(10, 1);
    // config packet for this node
    step(1, 1, cfg_word(23'h00_1234), 1, 0, 1);
    step(1, 1, 32'h4444_4444, 1, 1, 1);
    idle(6, 1);
    // config packet for another node is forwarded
    step(1, 1, {FMT, NID ^ 5'd1, 23'h7}, 0, 1, 1);
    idle(4, 1);
    // fill VC1, then overflow it
    for (int i = 0; i < DP; i++) step(1, 1, 32'h5000_0000 + i, 1, i == DP - 1, 0);
    step(1, 1, 32'h5555_5555, 1, 1, 0);
    idle(3, 0);
    idle(DP + 4, 1);
    // locked VC0 starves mid-packet while VC1 holds a whole packet
    step(1, 1, 32'h6000_0000, 0, 0, 1);
    step(1, 1, 32'h7000_0000, 1, 0, 1);
    step(1, 1, 32'h7000_0001, 1, 1, 1);
    idle(4, 1);
    step(1, 1, 32'h6000_0001, 0, 1, 1);
    idle(6, 1);
    // reset mid-packet, then a fresh packet
    step(1, 1, 32'h8000_0000, 0, 0, 1);
    step(1, 1, 32'h8000_0001, 0, 0, 0);
    step(1, 1, 32'h8000_0002, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(2, 1);
    step(1, 1, 32'h9000_0000, 1, 0, 1);
    step(1, 1, 32'h9000_0001, 1, 1, 1);
    idle(5, 1);
    // random traffic
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] f;
      f = $urandom;
      if ($urandom_range(3) == 0) f[31:23] = {FMT, NID};
      step($urandom_range(599) != 0, $urandom_range(9) < 6, f, $urandom_range(NV - 1),
           $urandom_range(9) < 3, (c % 400 < 60) ? 1'b0 : ($urandom_range(9) < 7));
    end
    idle(30, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
